// File: rtl/vram_write_sched.sv
// Write scheduler for the tile-video picture memories: queues CPU writes and
// retires them only during blanking, including a 300-entry tile-map fill.
module vram_write_sched #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_sel,
    input  logic [13:0] req_addr,
    input  logic [11:0] req_data,
    output logic        pal_we,
    output logic [3:0]  pal_addr,
    output logic [11:0] pal_wdata,
    output logic        tdef_we,
    output logic [13:0] tdef_addr,
    output logic [3:0]  tdef_wdata,
    output logic        tmap_we,
    output logic [8:0]  tmap_addr,
    output logic [5:0]  tmap_wdata,
    output logic        busy,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [11:0] H_LIM     = 12'(H_ACTIVE);
    localparam logic [11:0] V_LIM     = 12'(V_ACTIVE);
    localparam logic [13:0] TMAP_SIZE = 14'd300;
    localparam logic [8:0]  TMAP_LAST = 9'd299;

    typedef enum logic {RUN, FILL} state_t;

    state_t         state, state_nxt;
    logic [8:0]     fill_cnt, fill_cnt_nxt;
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;
    logic [1:0]     sel_mem  [DEPTH];
    logic [13:0]    addr_mem [DEPTH];
    logic [11:0]    data_mem [DEPTH];

    logic        blank, full, empty, push, pop;
    logic [1:0]  head_sel;
    logic [13:0] head_addr;
    logic [11:0] head_data;

    assign blank     = (x >= H_LIM) || (y >= V_LIM);
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign busy      = !empty || (state == FILL);
    assign head_sel  = sel_mem[rd_ptr];
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Request storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            sel_mem[wr_ptr]  <= req_sel;
            addr_mem[wr_ptr] <= req_addr;
            data_mem[wr_ptr] <= req_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            state    <= RUN;
            fill_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            state    <= state_nxt;
            fill_cnt <= fill_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fill_cnt_nxt = fill_cnt;
        pop          = 1'b0;
        err          = 1'b0;
        pal_we       = 1'b0;
        pal_addr     = head_addr[3:0];
        pal_wdata    = head_data;
        tdef_we      = 1'b0;
        tdef_addr    = head_addr;
        tdef_wdata   = head_data[3:0];
        tmap_we      = 1'b0;
        tmap_addr    = head_addr[8:0];
        tmap_wdata   = head_data[5:0];
        if (blank && !empty) begin
            case (state)
                RUN: begin
                    case (head_sel)
                        2'd0: begin
                            pal_we = 1'b1;
                            pop    = 1'b1;
                        end
                        2'd1: begin
                            tdef_we = 1'b1;
                            pop     = 1'b1;
                        end
                        2'd2: begin
                            if (head_addr < TMAP_SIZE) tmap_we = 1'b1;
                            else                       err     = 1'b1;
                            pop = 1'b1;
                        end
                        default: begin
                            // Setup cycle: the fill entry stays at the head as the data source.
                            fill_cnt_nxt = '0;
                            state_nxt    = FILL;
                        end
                    endcase
                end
                FILL: begin
                    tmap_we   = 1'b1;
                    tmap_addr = fill_cnt;
                    if (fill_cnt == TMAP_LAST) begin
                        pop          = 1'b1;
                        state_nxt    = RUN;
                        fill_cnt_nxt = '0;
                    end else begin
                        fill_cnt_nxt = fill_cnt + 9'd1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_write_sched.sv
// Bench for vram_write_sched: directed scenarios plus random traffic, checked
// against a model that expands each request into its expected blank-cycle events.
module tb_vram_write_sched;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] x = '0, y = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_sel = '0;
    logic [13:0] req_addr = '0;
    logic [11:0] req_data = '0;
    logic        pal_we, tdef_we, tmap_we, busy, err;
    logic [3:0]  pal_addr;
    logic [11:0] pal_wdata;
    logic [13:0] tdef_addr;
    logic [3:0]  tdef_wdata;
    logic [8:0]  tmap_addr;
    logic [5:0]  tmap_wdata;

    vram_write_sched #(.H_ACTIVE(320), .V_ACTIVE(240), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_addr(req_addr), .req_data(req_data),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .tdef_we(tdef_we), .tdef_addr(tdef_addr), .tdef_wdata(tdef_wdata),
        .tmap_we(tmap_we), .tmap_addr(tmap_addr), .tmap_wdata(tmap_wdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected events during blank cycles: 0 pal, 1 tdef, 2 tmap, 3 err, 4 idle (fill setup)
    typedef struct {
        int          kind;
        logic [13:0] addr;
        logic [11:0] data;
        bit          last;
    } ev_t;

    ev_t evq[$];
    int  occ = 0;
    int  total = 0;
    int  bad = 0;
    int  nwr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic add_req(input logic [1:0] s, input logic [13:0] a, input logic [11:0] d);
        ev_t e;
        e.addr = a; e.data = d; e.last = 1'b1;
        case (s)
            2'd0: begin e.kind = 0; e.addr = {10'd0, a[3:0]}; evq.push_back(e); end
            2'd1: begin e.kind = 1; e.data = {8'd0, d[3:0]}; evq.push_back(e); end
            2'd2: begin
                e.kind = (a < 14'd300) ? 2 : 3;
                e.data = {6'd0, d[5:0]};
                evq.push_back(e);
            end
            default: begin
                e.kind = 4; e.last = 1'b0;
                evq.push_back(e);
                for (int i = 0; i < 300; i++) begin
                    e.kind = 2; e.addr = 14'(i); e.data = {6'd0, d[5:0]};
                    e.last = (i == 299);
                    evq.push_back(e);
                end
            end
        endcase
        occ++;
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
    task automatic step(input int xv, input int yv, input bit v, input logic [1:0] s,
                        input logic [13:0] a, input logic [11:0] d, output bit acc);
        bit  blank;
        ev_t e;
        x = 12'(xv); y = 12'(yv);
        req_valid = v; req_sel = s; req_addr = a; req_data = d;
        @(negedge clk);
        blank = (xv >= 320) || (yv >= 240);
        e.kind = 5; e.addr = '0; e.data = '0; e.last = 1'b0;
        if (blank && evq.size() > 0) e = evq[0];
        chk("req_ready", 32'(req_ready), 32'(occ < DEPTH));
        chk("busy", 32'(busy), 32'(occ > 0));
        chk("pal_we", 32'(pal_we), 32'(e.kind == 0));
        chk("tdef_we", 32'(tdef_we), 32'(e.kind == 1));
        chk("tmap_we", 32'(tmap_we), 32'(e.kind == 2));
        chk("err", 32'(err), 32'(e.kind == 3));
        if (e.kind == 0) begin
            chk("pal_addr", 32'(pal_addr), 32'(e.addr));
            chk("pal_wdata", 32'(pal_wdata), 32'(e.data));
        end
        if (e.kind == 1) begin
            chk("tdef_addr", 32'(tdef_addr), 32'(e.addr));
            chk("tdef_wdata", 32'(tdef_wdata), 32'(e.data));
        end
        if (e.kind == 2) begin
            chk("tmap_addr", 32'(tmap_addr), 32'(e.addr));
            chk("tmap_wdata", 32'(tmap_wdata), 32'(e.data));
        end
        if (tmap_we) nwr++;
        acc = v && (occ < DEPTH);
        @(posedge clk);
        if (blank && evq.size() > 0) begin
            if (evq[0].last) occ--;
            void'(evq.pop_front());
        end
        if (acc) add_req(s, a, d);
        #1;
    endtask

    task automatic idle(input int n, input bit blank);
        bit acc;
        for (int i = 0; i < n; i++) step(blank ? 400 : 100, 50, 1'b0, 2'd0, 14'd0, 12'd0, acc);
    endtask

    task automatic push_wait(input int xv, input int yv, input logic [1:0] s,
                             input logic [13:0] a, input logic [11:0] d);
        bit acc = 1'b0;
        int tries = 0;
        while (!acc && tries < 50) begin
            step(xv, yv, 1'b1, s, a, d, acc);
            tries++;
        end
        chk("push_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (evq.size() > 0 && n < 2000) begin
            idle(1, 1'b1);
            n++;
        end
        chk("drain_timeout", 32'(evq.size()), 32'd0);
        idle(1, 1'b1);
    endtask

    initial begin
        int  w0;
        bit  acc;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_we", 32'({pal_we, tdef_we, tmap_we}), 32'd0);

        // Palette write held off through active video
        push_wait(100, 50, 2'd0, 14'd5, 12'hF80);
        idle(5, 1'b0);
        step(320, 50, 1'b0, 2'd0, 14'd0, 12'd0, acc);
        idle(2, 1'b1);

        // Fill the FIFO during active video, then release in blank
        for (int i = 0; i < 4; i++) push_wait(100, 10, 2'(i % 3), 14'(i + 7), 12'(i * 37 + 5));
        step(100, 10, 1'b1, 2'd1, 14'h0123, 12'h00B, acc);
        chk("full_reject", 32'(acc), 32'd0);
        push_wait(400, 10, 2'd1, 14'h0123, 12'h00B);
        drain();

        // Fill interrupted by active video
        w0 = nwr;
        push_wait(400, 0, 2'd3, 14'd0, 12'h02A);
        idle(150, 1'b1);
        idle(100, 1'b0);
        drain();
        chk("fill_count", 32'(nwr - w0), 32'd300);

        // Out-of-range tile map write, then corner tiledef write
        push_wait(400, 0, 2'd2, 14'd300, 12'h015);
        push_wait(400, 0, 2'd1, 14'h3FFF, 12'h007);
        drain();

        // Reset in the middle of a fill with two entries queued
        push_wait(100, 10, 2'd3, 14'd0, 12'h015);
        push_wait(100, 10, 2'd0, 14'd1, 12'h111);
        push_wait(100, 10, 2'd1, 14'd2, 12'h002);
        idle(151, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_mid_we", 32'({pal_we, tdef_we, tmap_we}), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        evq.delete();
        occ = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        w0 = nwr;
        idle(20, 1'b1);
        chk("post_rst_writes", 32'(nwr - w0), 32'd0);

        // Push coinciding with a pop at occupancy 2
        push_wait(100, 10, 2'd0, 14'd1, 12'h0A1);
        push_wait(100, 10, 2'd1, 14'd2, 12'h0A2);
        push_wait(400, 10, 2'd2, 14'd3, 12'h0A3);
        chk("occ_kept", 32'(occ), 32'd2);
        drain();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            int xv, yv, sv;
            xv = ($urandom_range(0, 9) < 6) ? int'($urandom_range(320, 399)) : int'($urandom_range(0, 319));
            yv = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 239)) : int'($urandom_range(240, 260));
            sv = ($urandom_range(0, 59) == 0) ? 3 : int'($urandom_range(0, 2));
            step(xv, yv, 1'($urandom_range(0, 1)), 2'(sv),
                 ($urandom_range(0, 3) == 0) ? 14'($urandom_range(290, 320)) : 14'($urandom),
                 12'($urandom), acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
